key_ctrl: RTL and testbench
===========================

# key_ctrl

Front-panel key reader for the digital clock. It takes the three raw active-low push-buttons (mode, select, increment) and synchronises and debounces them. It then generates the mode code `mk` and field code `k1` consumed by the time-setting display driver, plus single-cycle increment strobes (with hold-to-repeat) for the time/alarm counters. It sits between the board pins and the counter and display logic, and is the input-side counterpart of the display scanner.

## Interface
- `DEB_CYCLES`, default 20: consecutive stable `fs` cycles required to accept a key level change.
- `REP_DELAY`, default 500: `fs` cycles a held increment key waits before auto-repeat starts.
- `REP_PERIOD`, default 100: `fs` cycles between auto-repeat strobes.
- `fs`, input, 1: system clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `key_mode_n`, input, 1: raw mode button, 0 = pressed, asynchronous to `fs`.
- `key_sel_n`, input, 1: raw field-select button, 0 = pressed.
- `key_inc_n`, input, 1: raw increment button, 0 = pressed.
- `mk`, output, 2: mode code; 00 run, 01 alarm view, 10 alarm set, 11 time set.
- `k1`, output, 2: field code within the current setting mode.
- `inc_pulse`, output, 1: one-cycle increment strobe for the selected field.
- `key_level`, output, 3: debounced pressed levels {inc, sel, mode}, 1 = pressed.

## Operation
- **Synchroniser**
  - Each key passes through a 2-flop synchroniser.
  - Synchroniser flops reset to 1 (released).
- **Debouncer, per key**
  - Holds a stable level that resets to released.
  - Holds a counter of width `$clog2(DEB_CYCLES+1)`.
  - Counter clears whenever the synchronised input equals the stable level.
  - Counter otherwise increments.
  - When the count reaches `DEB_CYCLES`, the stable level flips and the counter clears.
  - Glitches shorter than `DEB_CYCLES` cycles are ignored entirely.
- **Press event:** a stable released→pressed transition, lasting one cycle. Releases generate no event except for ending repeat.
- **Mode press**
  - `mk <= mk + 1`, wrapping 11→00.
  - `k1 <= 00` in the same cycle.
- **Select press**
  - When `mk != 00`: `k1 <= k1 + 1`, wrapping 11→00.
  - When `mk == 00`: ignored.
- **Increment key, 3-state FSM**
  - IDLE: on an inc press with `mk` in {10, 11}, assert `inc_pulse`, load the repeat counter with `REP_DELAY`, and go to DELAY.
  - DELAY: the counter decrements. At 0, assert `inc_pulse`, load `REP_PERIOD`, and go to REPEAT.
  - REPEAT: at 0, assert `inc_pulse` and reload `REP_PERIOD`.
  - Any state: inc release or `mk` leaving {10, 11} returns to IDLE with no pulse.
- **Modes 00 and 01:** inc presses produce no pulse.
- **Simultaneous events**
  - Mode press and select press in one cycle: mode wins, `k1 = 00`.
  - Mode press and any inc strobe in one cycle: the strobe is suppressed and the FSM returns to IDLE.
  - Select press and inc strobe in one cycle: both take effect; the strobe applies to the new field.
- **Reset**
  - Asserting `rst_n` low mid-operation immediately forces all outputs to 0.
  - The FSM goes to IDLE, all counters clear, and all stable levels return to released.
  - The first press after reset release is processed normally.

## Timing
- All outputs are registered. Reset values: `mk = 00`, `k1 = 00`, `inc_pulse = 0`, `key_level = 000`.
- **Press latency:** if a key pin is low from before rising edge E0 onward, the debounced level and the resulting `mk`/`k1` change or first `inc_pulse` appear after edge E0 + `DEB_CYCLES` + 2 (2 synchroniser edges, then `DEB_CYCLES` counting edges). `key_level` updates on that same edge.
- **Release latency:** identical, `DEB_CYCLES` + 2 edges.
- **Repeat timing**
  - The second `inc_pulse` comes exactly `REP_DELAY` cycles after the first.
  - Later pulses are spaced exactly `REP_PERIOD` cycles apart.
  - `inc_pulse` is never high for two consecutive cycles, provided `REP_DELAY` and `REP_PERIOD` are ≥ 2; this is required.

## Structure
- **Shared package `clock_pkg`**
  - Mode constants: `MK_RUN` = 00, `MK_ALM_VIEW` = 01, `MK_ALM_SET` = 10, `MK_TIME_SET` = 11.
  - Increment-FSM state enum: IDLE, DELAY, REPEAT.
- **Sub-module `key_debounce`:** 2-flop synchroniser, stable level and counter, with `DEB_CYCLES` as a parameter. Outputs are `level` and a one-cycle `press`. Instantiated 3 times.
- The top level holds the `mk`/`k1` registers and the increment FSM.

## Test plan
All scenarios use `DEB_CYCLES` = 4, `REP_DELAY` = 10, `REP_PERIOD` = 5.
- **Reset:** hold `rst_n` low, then release → `mk = 00`, `k1 = 00`, `inc_pulse = 0`, `key_level = 000`; outputs stay there with no keys pressed.
- **Bounce rejection:** mode pin low 3 cycles, high 1, low 3, then held low → no change until 4 stable cycles; `mk` becomes 01 exactly 6 edges after the final stable low begins.
- **Mode and field walk:** 5 clean mode presses → `mk` steps 01, 10, 11, 00, 01 with `k1` held 00. Then in `mk = 11`, 3 select presses → `k1` steps 01, 10, 11; then a mode press → `mk = 00`, `k1 = 00`.
- **Hold-to-repeat:** `mk = 11`, inc held 40 cycles after debounce → pulses at offsets 0, 10, 15, 20, 25, 30, 35; release → no further pulses. In `mk = 00`, the same stimulus gives zero pulses.
- **Simultaneous mode and inc:** in `mk = 10`, mode and inc debounce in the same cycle → `mk = 11`, `k1 = 00`, no `inc_pulse`.
- **Reset mid-repeat:** pull `rst_n` low during REPEAT → `inc_pulse` and `mk` drop to 0 asynchronously; after release, inc is still held but `mk = 00`, so no pulses occur.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock front end: mode codes and the
// increment auto-repeat state encoding.
package clock_pkg;

    localparam logic [1:0] MK_RUN      = 2'b00;
    localparam logic [1:0] MK_ALM_VIEW = 2'b01;
    localparam logic [1:0] MK_ALM_SET  = 2'b10;
    localparam logic [1:0] MK_TIME_SET = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } inc_state_t;

    // True in the two modes where the increment key edits a field.
    function automatic logic is_setting(input logic [1:0] mode);
        return (mode == MK_ALM_SET) || (mode == MK_TIME_SET);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser followed by a stable-level debouncer.
// press/rel are single-cycle strobes on the edge where the level flips.
module key_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic fs,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          sync_pressed;
    logic          flip;
    logic [CW-1:0] cnt;

    // Synchroniser chain; idle pin level is 1 (released).
    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign sync_pressed = ~sync2;
    // Count reaching DEB_CYCLES on this edge accepts the new level.
    assign flip  = (sync_pressed != level) && (cnt == CW'(DEB_CYCLES - 1));
    assign press = flip & sync_pressed;
    assign rel   = flip & ~sync_pressed;

    // Stable level and disagreement counter.
    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= {CW{1'b0}};
        end else if (sync_pressed == level) begin
            cnt   <= {CW{1'b0}};
        end else if (flip) begin
            level <= sync_pressed;
            cnt   <= {CW{1'b0}};
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/key_ctrl.sv
// Front-panel key reader: debounced mode/select/increment keys driving the
// mode code, field code and hold-to-repeat increment strobe.
module key_ctrl #(
    parameter int DEB_CYCLES = 20,
    parameter int REP_DELAY  = 500,
    parameter int REP_PERIOD = 100
) (
    input  logic       fs,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_sel_n,
    input  logic       key_inc_n,
    output logic [1:0] mk,
    output logic [1:0] k1,
    output logic       inc_pulse,
    output logic [2:0] key_level
);

    import clock_pkg::*;

    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic          mode_level, sel_level, inc_level;
    logic          mode_press, sel_press, inc_press;
    logic          inc_rel;
    logic [1:0]    unused_rel;
    logic          setting;
    logic          inc_hold;
    inc_state_t    state, state_next;
    logic [RW-1:0] rep_cnt, rep_cnt_next;
    logic [1:0]    mk_next, k1_next;
    logic          pulse_next;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .fs(fs), .rst_n(rst_n), .key_n(key_mode_n),
        .level(mode_level), .press(mode_press), .rel(unused_rel[0])
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
        .fs(fs), .rst_n(rst_n), .key_n(key_sel_n),
        .level(sel_level), .press(sel_press), .rel(unused_rel[1])
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .fs(fs), .rst_n(rst_n), .key_n(key_inc_n),
        .level(inc_level), .press(inc_press), .rel(inc_rel)
    );

    assign key_level = {inc_level, sel_level, mode_level};
    assign setting   = is_setting(mk);
    // A release accepted on this edge already cancels any strobe due now.
    assign inc_hold  = inc_level & ~inc_rel;

    // Next mode/field codes and increment FSM transitions.
    always_comb begin
        mk_next      = mk;
        k1_next      = k1;
        state_next   = state;
        rep_cnt_next = rep_cnt;
        pulse_next   = 1'b0;

        if (mode_press) begin
            mk_next = mk + 2'b01;
            k1_next = 2'b00;
        end else if (sel_press && (mk != MK_RUN)) begin
            k1_next = k1 + 2'b01;
        end else begin
            k1_next = k1;
        end

        case (state)
            IDLE: begin
                if (inc_press && setting && !mode_press) begin
                    pulse_next   = 1'b1;
                    rep_cnt_next = RW'(REP_DELAY - 1);
                    state_next   = DELAY;
                end else begin
                    state_next   = IDLE;
                end
            end
            DELAY, REPEAT: begin
                if (mode_press || !inc_hold || !setting) begin
                    state_next   = IDLE;
                    rep_cnt_next = {RW{1'b0}};
                end else if (rep_cnt == {RW{1'b0}}) begin
                    pulse_next   = 1'b1;
                    rep_cnt_next = RW'(REP_PERIOD - 1);
                    state_next   = REPEAT;
                end else begin
                    rep_cnt_next = rep_cnt - RW'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                rep_cnt_next = {RW{1'b0}};
            end
        endcase
    end

    // Registered outputs and FSM state.
    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            mk        <= MK_RUN;
            k1        <= 2'b00;
            inc_pulse <= 1'b0;
            state     <= IDLE;
            rep_cnt   <= {RW{1'b0}};
        end else begin
            mk        <= mk_next;
            k1        <= k1_next;
            inc_pulse <= pulse_next;
            state     <= state_next;
            rep_cnt   <= rep_cnt_next;
        end
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl: directed scenarios plus random key activity, checked
// every cycle against a history-based behavioural model.
module tb_key_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       fs = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_sel_n = 1'b1;
    logic       key_inc_n = 1'b1;
    logic [1:0] mk;
    logic [1:0] k1;
    logic       inc_pulse;
    logic [2:0] key_level;

    key_ctrl #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
        .fs(fs), .rst_n(rst_n),
        .key_mode_n(key_mode_n), .key_sel_n(key_sel_n), .key_inc_n(key_inc_n),
        .mk(mk), .k1(k1), .inc_pulse(inc_pulse), .key_level(key_level)
    );

    always #5 fs = ~fs;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: raw pin history per key, indexed by edge number.
    bit         pin_hist[3][64];
    int         t = 0;
    int         t_rst = 0;
    bit         m_lvl[3];
    logic [1:0] m_mk, m_k1;
    logic       m_pulse;
    bit         hold_active;
    int         hold_start;
    int         tick_no = 0;
    int         pulse_ticks[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit pin_at(input int k, input int i);
        if (i < t_rst) return 1'b1;
        return pin_hist[k][i % 64];
    endfunction

    task automatic model_reset();
        m_mk = 2'b00; m_k1 = 2'b00; m_pulse = 1'b0;
        for (int k = 0; k < 3; k++) m_lvl[k] = 1'b0;
        hold_active = 1'b0;
        t_rst = t;
    endtask

    task automatic model_edge();
        bit pins[3];
        bit nl[3];
        bit pr[3];
        bit all_diff;
        bit setting;
        int h;
        pins[0] = key_mode_n; pins[1] = key_sel_n; pins[2] = key_inc_n;
        for (int k = 0; k < 3; k++) pin_hist[k][t % 64] = pins[k];
        // Level flips once the last DEB synchronised samples all disagree.
        for (int k = 0; k < 3; k++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if ((pin_at(k, t - j) == 1'b0) == m_lvl[k]) all_diff = 1'b0;
            nl[k] = all_diff ? !m_lvl[k] : m_lvl[k];
            pr[k] = all_diff && nl[k];
        end
        setting = (m_mk >= 2'd2);
        if (pr[0]) begin
            hold_active = 1'b0; m_pulse = 1'b0;
        end else if (pr[2]) begin
            hold_active = setting; hold_start = t; m_pulse = setting;
        end else if (hold_active && nl[2] && setting) begin
            h = t - hold_start;
            m_pulse = (h == RD) || (h > RD && ((h - RD) % RP) == 0);
        end else begin
            hold_active = 1'b0; m_pulse = 1'b0;
        end
        if (pr[0]) begin
            m_mk = m_mk + 2'd1; m_k1 = 2'd0;
        end else if (pr[1] && m_mk != 2'd0) begin
            m_k1 = m_k1 + 2'd1;
        end
        for (int k = 0; k < 3; k++) m_lvl[k] = nl[k];
        t++;
    endtask

    task automatic tick();
        @(posedge fs);
        if (rst_n) model_edge();
        #2;
        tick_no++;
        if (inc_pulse === 1'b1) pulse_ticks.push_back(tick_no);
        check("mk", 8'(mk), 8'(m_mk));
        check("k1", 8'(k1), 8'(m_k1));
        check("inc_pulse", 8'(inc_pulse), 8'(m_pulse));
        check("key_level", 8'(key_level), 8'({m_lvl[2], m_lvl[1], m_lvl[0]}));
    endtask

    task automatic set_pin(input int k, input logic v);
        case (k)
            0: key_mode_n = v;
            1: key_sel_n  = v;
            default: key_inc_n = v;
        endcase
    endtask

    task automatic press(input int k, input int lo, input int hi);
        set_pin(k, 1'b0);
        repeat (lo) tick();
        set_pin(k, 1'b1);
        repeat (hi) tick();
    endtask

    // Asynchronous reset pulse asserted mid-cycle, away from any edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_mk", 8'(mk), 8'd0);
        check("arst_k1", 8'(k1), 8'd0);
        check("arst_pulse", 8'(inc_pulse), 8'd0);
        check("arst_level", 8'(key_level), 8'd0);
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_mk[5];
        int exp_off[7];
        int start;
        exp_mk  = '{1, 2, 3, 0, 1};
        exp_off = '{0, 10, 15, 20, 25, 30, 35};

        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        // Bounce rejection.
        key_mode_n = 1'b0; repeat (3) tick();
        key_mode_n = 1'b1; repeat (1) tick();
        key_mode_n = 1'b0; repeat (3) tick();
        key_mode_n = 1'b1; repeat (1) tick();
        key_mode_n = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 5) check("bounce_e5", 8'(mk), 8'd0);
            if (j == 6) check("bounce_e6", 8'(mk), 8'd1);
        end
        repeat (4) tick();
        key_mode_n = 1'b1; repeat (8) tick();

        // Mode and field walk.
        async_reset();
        for (int i = 0; i < 5; i++) begin
            press(0, 8, 8);
            check("walk_mk", 8'(mk), 8'(exp_mk[i]));
            check("walk_k1", 8'(k1), 8'd0);
        end
        press(0, 8, 8); press(0, 8, 8);
        for (int i = 1; i <= 3; i++) begin
            press(1, 8, 8);
            check("walk_sel", 8'(k1), 8'(i));
        end
        press(0, 8, 8);
        check("walk_wrap_mk", 8'(mk), 8'd0);
        check("walk_wrap_k1", 8'(k1), 8'd0);

        // Hold-to-repeat in time-set mode.
        press(0, 8, 8); press(0, 8, 8); press(0, 8, 8);
        pulse_ticks.delete();
        start = tick_no;
        key_inc_n = 1'b0; repeat (40) tick();
        key_inc_n = 1'b1; repeat (20) tick();
        check("rep_count", 8'(pulse_ticks.size()), 8'd7);
        if (pulse_ticks.size() > 0) check("rep_first", 8'(pulse_ticks[0] - start), 8'd6);
        for (int i = 0; i < 7 && i < pulse_ticks.size(); i++)
            check("rep_offset", 8'(pulse_ticks[i] - pulse_ticks[0]), 8'(exp_off[i]));

        // Same hold in run mode gives nothing.
        press(0, 8, 8);
        pulse_ticks.delete();
        key_inc_n = 1'b0; repeat (40) tick();
        key_inc_n = 1'b1; repeat (20) tick();
        check("run_no_pulse", 8'(pulse_ticks.size()), 8'd0);

        // Mode and inc accepted on the same edge.
        press(0, 8, 8); press(0, 8, 8);
        pulse_ticks.delete();
        key_mode_n = 1'b0; key_inc_n = 1'b0; repeat (30) tick();
        key_mode_n = 1'b1; key_inc_n = 1'b1; repeat (8) tick();
        check("simul_mk", 8'(mk), 8'd3);
        check("simul_k1", 8'(k1), 8'd0);
        check("simul_pulses", 8'(pulse_ticks.size()), 8'd0);

        // Reset during auto-repeat with inc still held.
        async_reset();
        press(0, 8, 8); press(0, 8, 8); press(0, 8, 8);
        key_inc_n = 1'b0; repeat (21) tick();
        check("mid_pulse", 8'(inc_pulse), 8'd1);
        async_reset();
        pulse_ticks.delete();
        repeat (40) tick();
        check("post_rst_pulses", 8'(pulse_ticks.size()), 8'd0);
        check("post_rst_level", 8'(key_level), 8'b100);
        key_inc_n = 1'b1; repeat (10) tick();

        // Random key activity; increment toggles slowly to reach repeat.
        async_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) key_mode_n = ~key_mode_n;
            if ($urandom_range(0, 7) == 0) key_sel_n = ~key_sel_n;
            if ($urandom_range(0, 39) == 0) key_inc_n = ~key_inc_n;
            if ($urandom_range(0, 499) == 0) async_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
